// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - classifies debounced button gestures as short, long or double press
// One five-state FSM with a shared saturating duration counter; every output is registered.
module button_press_classifier #(
  parameter int CNT_WIDTH  = 26,
  parameter int LONG_TICKS = 50_000_000,
  parameter int GAP_TICKS  = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic db_in,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_LONG_HOLD,
    S_WAIT_GAP,
    S_PRESS2
  } state_t;

  // The edge cycle itself is the first sample of a run and the counter starts
  // at 0 one cycle later, so the Nth sample of a run sees r_cnt == N-2.
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_TICKS - 2);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_TICKS - 2);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_db_q;
  logic                 w_rise;
  logic                 w_fall;
  logic [CNT_WIDTH-1:0] w_cnt_inc;

  assign w_rise    = db_in & ~r_db_q;
  assign w_fall    = ~db_in & r_db_q;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_db_q       <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      hold         <= 1'b0;
    end else begin
      r_db_q       <= db_in;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_PRESS1;
            r_cnt   <= '0;
          end
        end
        S_PRESS1: begin
          if (w_fall) begin
            r_state <= S_WAIT_GAP;
            r_cnt   <= '0;
          end else if (r_cnt == LONG_LAST) begin
            r_state    <= S_LONG_HOLD;
            r_cnt      <= '0;
            long_press <= 1'b1;
            hold       <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_LONG_HOLD: begin
          if (w_fall) begin
            r_state <= S_IDLE;
            hold    <= 1'b0;
          end
        end
        S_WAIT_GAP: begin
          // A rise always beats gap expiry: the rising sample is not a low sample.
          if (w_rise) begin
            r_state <= S_PRESS2;
            r_cnt   <= '0;
          end else if (r_cnt == GAP_LAST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            short_press <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_PRESS2: begin
          if (w_fall) begin
            r_state      <= S_IDLE;
            double_press <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          hold    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// tb/tb_button_press_classifier.sv - self-checking bench for button_press_classifier
// Run-length gesture model compared every cycle, plus literal latency and pulse-count checks.
module tb_button_press_classifier;

  localparam int CW = 8;
  localparam int LT = 100;
  localparam int GT = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic db_in = 1'b0;
  logic short_press, long_press, double_press, hold;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int n_short, n_long, n_double, n_hold;
  int e_short, e_long, e_double;

  // gesture model: run lengths of the current first press / gap, flags for later phases
  logic m_prev;
  int   m_press_len;
  int   m_gap_len;
  bit   m_second;
  bit   m_long;
  logic exp_short, exp_long, exp_double, exp_hold;

  button_press_classifier #(
    .CNT_WIDTH (CW),
    .LONG_TICKS(LT),
    .GAP_TICKS (GT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .db_in       (db_in),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .hold        (hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_prev      = 1'b0;
    m_press_len = -1;
    m_gap_len   = -1;
    m_second    = 1'b0;
    m_long      = 1'b0;
    exp_short   = 1'b0;
    exp_long    = 1'b0;
    exp_double  = 1'b0;
    exp_hold    = 1'b0;
  endtask

  task automatic model_step(input logic v);
    logic rise;
    rise       = v & ~m_prev;
    m_prev     = v;
    exp_short  = 1'b0;
    exp_long   = 1'b0;
    exp_double = 1'b0;
    if (m_long) begin
      if (!v) begin
        m_long   = 1'b0;
        exp_hold = 1'b0;
      end
    end else if (m_second) begin
      if (!v) begin
        m_second   = 1'b0;
        exp_double = 1'b1;
      end
    end else if (m_gap_len >= 0) begin
      if (v) begin
        m_gap_len = -1;
        m_second  = 1'b1;
      end else begin
        m_gap_len++;
        if (m_gap_len == GT) begin
          exp_short = 1'b1;
          m_gap_len = -1;
        end
      end
    end else if (m_press_len >= 0) begin
      if (!v) begin
        m_press_len = -1;
        m_gap_len   = 1;
      end else begin
        m_press_len++;
        if (m_press_len == LT) begin
          m_press_len = -1;
          m_long      = 1'b1;
          exp_long    = 1'b1;
          exp_hold    = 1'b1;
        end
      end
    end else if (rise) begin
      m_press_len = 1;
    end
  endtask

  initial model_reset();

  // Edge numbering: a pulse decided on the sample taken at edge N is counted at edge N.
  always @(posedge clk) begin
    cyc++;
    if (reset) model_reset();
    else model_step(db_in);
    #1;
    check("outputs{short,long,double,hold}",
          int'({short_press, long_press, double_press, hold}),
          int'({exp_short, exp_long, exp_double, exp_hold}));
    if (short_press) begin n_short++; e_short = cyc; end
    if (long_press) begin n_long++; e_long = cyc; end
    if (double_press) begin n_double++; e_double = cyc; end
    if (hold) n_hold++;
  end

  task automatic clear_counts();
    n_short = 0; n_long = 0; n_double = 0; n_hold = 0;
    e_short = -1000; e_long = -1000; e_double = -1000;
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      db_in = v;
    end
  endtask

  task automatic mark(input logic v, output int edge_no);
    @(negedge clk);
    db_in   = v;
    edge_no = cyc + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl, fh, fr, sf;
    clear_counts();
    reset = 1'b1;
    db_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({short_press, long_press, double_press, hold}), 0);
    reset = 1'b0;
    drive(1'b0, 200);
    check("idle_activity", n_short + n_long + n_double + n_hold, 0);

    // short press: 20 high, pulse at the 50th low sample
    clear_counts();
    drive(1'b1, 20);
    mark(1'b0, fl);
    drive(1'b0, 59);
    check("short_count", n_short, 1);
    check("short_latency", e_short - fl, 49);
    check("short_no_other", n_long + n_double + n_hold, 0);

    // long press: 150 high
    clear_counts();
    mark(1'b1, fh);
    drive(1'b1, 149);
    mark(1'b0, fr);
    drive(1'b0, 59);
    check("long_count", n_long, 1);
    check("long_latency", e_long - fh, 99);
    check("long_hold_cycles", n_hold, 51);
    check("long_release_edge", fr - fh, 150);
    check("long_no_short", n_short + n_double, 0);

    // boundary: 99 high is short
    clear_counts();
    drive(1'b1, 99);
    drive(1'b0, 60);
    check("len99_short", n_short, 1);
    check("len99_long", n_long, 0);

    // boundary: exactly 100 high is long
    clear_counts();
    drive(1'b1, 100);
    drive(1'b0, 60);
    check("len100_long", n_long, 1);
    check("len100_short", n_short, 0);
    check("len100_hold", n_hold, 1);

    // double press
    clear_counts();
    drive(1'b1, 20);
    drive(1'b0, 10);
    drive(1'b1, 20);
    mark(1'b0, sf);
    drive(1'b0, 99);
    check("double_count", n_double, 1);
    check("double_latency", e_double - sf, 0);
    check("double_no_short", n_short + n_long, 0);

    // gap of 49 lows still pairs into a double press
    clear_counts();
    drive(1'b1, 20);
    drive(1'b0, 49);
    drive(1'b1, 20);
    drive(1'b0, 60);
    check("gap49_double", n_double, 1);
    check("gap49_short", n_short, 0);

    // gap of 50 lows finalises a short press; second press is a fresh short
    clear_counts();
    drive(1'b1, 20);
    drive(1'b0, 50);
    drive(1'b1, 20);
    drive(1'b0, 60);
    check("gap50_short", n_short, 2);
    check("gap50_double", n_double, 0);

    // reset in the middle of the gap discards the gesture
    clear_counts();
    drive(1'b1, 20);
    drive(1'b0, 25);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 100);
    check("reset_gap_pulses", n_short + n_long + n_double, 0);

    // reset during hold clears immediately; a still-held button is a new press
    clear_counts();
    drive(1'b1, 120);
    @(negedge clk);
    check("hold_before_reset", int'(hold), 1);
    reset = 1'b1;
    #1;
    check("async_reset_hold", int'(hold), 0);
    @(negedge clk);
    reset = 1'b0;
    clear_counts();
    drive(1'b1, 100);
    drive(1'b0, 10);
    check("held_after_reset_long", n_long, 1);
    check("held_after_reset_short", n_short + n_double, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_press_classifier.md
Name: button_press_classifier

Overview:
- Sits directly downstream of early_detect_debounce; consumes its debounced level `out` as `db_in`.
- Classifies each button gesture as short, long or double press.
- Emits one-cycle event pulses plus a hold level for the application/UI FSM.
- Single clock domain. `db_in` is already glitch-free and synchronous to `clk`, so no input synchronizer is needed.

Parameters:
- CNT_WIDTH, 26, width of the shared duration counter; must hold max(LONG_TICKS, GAP_TICKS).
- LONG_TICKS, 50_000_000, consecutive high cycles that qualify a long press (500 ms at 100 MHz).
- GAP_TICKS, 25_000_000, consecutive low cycles after a short press before it is final (250 ms).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- db_in  input  1  debounced button level from early_detect_debounce.
- short_press  output  1  one-cycle pulse; a completed short press with no second press inside the gap.
- long_press  output  1  one-cycle pulse; button held for LONG_TICKS cycles.
- double_press  output  1  one-cycle pulse; second press released within the gap window.
- hold  output  1  level; high from the long_press pulse cycle until release.

Behaviour:
- Reset:
  - Asynchronous, active-high. State goes to IDLE; counter = 0; db_q = 0.
  - All outputs 0. Takes effect immediately, in any state.
- Edge detect:
  - db_q is a registered copy of db_in.
  - rise = db_in & ~db_q; fall = ~db_in & db_q.
  - If db_in is high when reset deasserts, that counts as a rise (a press).
- Outputs: all registered, no combinational paths from db_in. Each pulse is high for exactly one clock.
- Counter:
  - Cleared to 0 on every state transition; increments once per cycle while in a timed state.
  - Saturates at all-ones; never wraps.
- Term definitions:
  - Press length L = consecutive cycles db_in is sampled high, starting with the rise cycle.
  - Gap G = consecutive cycles sampled low after a fall.
- IDLE: on rise -> PRESS1.
- PRESS1 (timing first press):
  - On fall with L < LONG_TICKS -> WAIT_GAP.
  - When L reaches LONG_TICKS with db_in still high -> LONG_HOLD. long_press pulses and hold rises in the next cycle.
- LONG_HOLD:
  - hold = 1 while in this state.
  - On fall -> IDLE; hold drops the next cycle.
  - No short_press or double_press is ever generated from a long press.
- WAIT_GAP (timing gap):
  - On rise with G < GAP_TICKS -> PRESS2.
  - When G reaches GAP_TICKS -> IDLE, with short_press pulsed the next cycle.
- PRESS2 (second press):
  - On fall -> IDLE, with double_press pulsed the next cycle.
  - Press length is not timed; holding the second press never yields long_press.
- Simultaneous events:
  - Fall on the exact cycle L would reach LONG_TICKS: cannot occur, because that sample is low, so L < LONG_TICKS and the press is short.
  - Rise on the cycle G would reach GAP_TICKS: cannot occur, because that sample is high, so G < GAP_TICKS and the gesture goes to PRESS2.
- At most one of short_press / long_press / double_press is high in any cycle.
- Reset mid-gesture: the gesture in progress is discarded and no pulse is emitted afterwards. A press still held after reset counts as a new rise.
- Size: one 5-state FSM, one CNT_WIDTH counter, an edge register and three pulse registers.

Test Plan (bench uses LONG_TICKS=100, GAP_TICKS=50, CNT_WIDTH=8, 10 ns clk):
- Reset: assert reset with db_in=0 -> all outputs 0 and held at 0 for 200 cycles of idle input.
- Short press: db_in high 20 cycles, then low -> exactly one short_press pulse, 50 cycles after the first low sample. long_press, double_press and hold stay 0.
- Long press: db_in high 150 cycles -> long_press pulse one cycle after the 100th high sample. hold stays 1 until one cycle after release; no short_press on release or 60 cycles later.
- Long-press boundary:
  - High for 99 cycles -> short_press only (after the gap).
  - High for exactly 100 cycles -> long_press only.
- Double press: high 20, low 10, high 20, low -> one double_press pulse, the cycle after the second fall is sampled. No short_press within the following 100 cycles.
- Gap boundary and reset:
  - High 20, low exactly 49, high 20, low -> double_press.
  - Same pattern with the gap at 50 -> short_press, then a new press sequence.
  - Reset pulse at gap cycle 25 -> no pulse for 100 cycles after.
